// File: rtl/hazard_pkg.sv
// Shared constants for the multi-cycle hazard unit: forward-select encodings,
// parameter defaults and a saturating-increment helper for the performance counters.
package hazard_pkg;

    localparam int REG_AW_DEFAULT  = 5;
    localparam int MDU_LAT_DEFAULT = 4;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == '1) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/hazard_fwd_sel.sv
// Forward-select for one E-stage source operand. The M stage outranks W because
// it holds the younger result; x0 is never forwarded.
module hazard_fwd_sel
    import hazard_pkg::*;
#(
    parameter int REG_AW = REG_AW_DEFAULT
) (
    input  logic [REG_AW-1:0] rs,
    input  logic [REG_AW-1:0] rd_m,
    input  logic [REG_AW-1:0] rd_w,
    input  logic              reg_write_m,
    input  logic              reg_write_w,
    output logic [1:0]        fwd
);

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        fwd = FWD_RF;
        if (rs != '0 && rs == rd_m && reg_write_m) begin
            fwd = FWD_MEM;
        end else if (rs != '0 && rs == rd_w && reg_write_w) begin
            fwd = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_unit_mc.sv
// 5-stage pipeline hazard unit with multi-cycle MDU occupancy tracking.
// Optional cycle/event counters are built when HAZARD_PERF_CNT_EN is defined.
module hazard_unit_mc
    import hazard_pkg::*;
#(
    parameter int REG_AW  = REG_AW_DEFAULT,
    parameter int MDU_LAT = MDU_LAT_DEFAULT
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [REG_AW-1:0] Rs1D,
    input  logic [REG_AW-1:0] Rs2D,
    input  logic [REG_AW-1:0] Rs1E,
    input  logic [REG_AW-1:0] Rs2E,
    input  logic [REG_AW-1:0] RdE,
    input  logic [REG_AW-1:0] RdM,
    input  logic [REG_AW-1:0] RdW,
    input  logic              RegWriteM,
    input  logic              RegWriteW,
    input  logic              ResultSrcE0,
    input  logic              PCSrcE,
    input  logic              MduOpE,
    output logic              StallF,
    output logic              StallD,
    output logic              StallE,
    output logic              FlushD,
    output logic              FlushE,
    output logic              FlushM,
    output logic [1:0]        ForwardAE,
    output logic [1:0]        ForwardBE,
    output logic              MduDoneE
`ifdef HAZARD_PERF_CNT_EN
    ,
    input  logic              PerfClr,
    output logic [31:0]       StallCycles,
    output logic [31:0]       MduStallCycles,
    output logic [31:0]       FlushEvents
`endif
);

    localparam int CNT_W = $clog2(MDU_LAT) + 1;

    logic [CNT_W-1:0] mdu_cnt_q, mdu_cnt_d;
    logic             lw_stall, mdu_stall;

    hazard_fwd_sel #(.REG_AW(REG_AW)) u_fwd_a (
        .rs(Rs1E), .rd_m(RdM), .rd_w(RdW),
        .reg_write_m(RegWriteM), .reg_write_w(RegWriteW), .fwd(ForwardAE)
    );

    hazard_fwd_sel #(.REG_AW(REG_AW)) u_fwd_b (
        .rs(Rs2E), .rd_m(RdM), .rd_w(RdW),
        .reg_write_m(RegWriteM), .reg_write_w(RegWriteW), .fwd(ForwardBE)
    );

    assign lw_stall  = ResultSrcE0 && (RdE != '0) && (Rs1D == RdE || Rs2D == RdE);
    assign MduDoneE  = MduOpE && (mdu_cnt_q == CNT_W'(MDU_LAT - 1));
    assign mdu_stall = MduOpE && !MduDoneE;

    // A dropped MduOpE (e.g. the op was flushed) abandons the count as well.
    always_comb begin
        mdu_cnt_d = '0;
        if (mdu_stall) begin
            mdu_cnt_d = mdu_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: state flops use non-blocking assignments so all updates land together at the edge.
        if (!reset_n) begin
            mdu_cnt_q <= '0;
        end else begin
            mdu_cnt_q <= mdu_cnt_d;
        end
    end

    // An MDU op owns E, so it outranks any branch; a branch outranks load-use.
    always_comb begin
        StallF = 1'b0;
        StallD = 1'b0;
        StallE = 1'b0;
        FlushD = 1'b0;
        FlushE = 1'b0;
        FlushM = 1'b0;
        if (mdu_stall) begin
            StallF = 1'b1;
            StallD = 1'b1;
            StallE = 1'b1;
            FlushM = 1'b1;
        end else if (PCSrcE) begin
            FlushD = 1'b1;
            FlushE = 1'b1;
        end else if (lw_stall) begin
            StallF = 1'b1;
            StallD = 1'b1;
            FlushE = 1'b1;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cycles_q, stall_cycles_d;
    logic [31:0] mdu_stall_cycles_q, mdu_stall_cycles_d;
    logic [31:0] flush_events_q, flush_events_d;

    always_comb begin
        stall_cycles_d     = stall_cycles_q;
        mdu_stall_cycles_d = mdu_stall_cycles_q;
        flush_events_d     = flush_events_q;
        if (PerfClr) begin
            stall_cycles_d     = '0;
            mdu_stall_cycles_d = '0;
            flush_events_d     = '0;
        end else begin
            if (StallF)             stall_cycles_d     = sat_inc(stall_cycles_q);
            if (mdu_stall)          mdu_stall_cycles_d = sat_inc(mdu_stall_cycles_q);
            if (PCSrcE && !mdu_stall) flush_events_d   = sat_inc(flush_events_q);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cycles_q     <= '0;
            mdu_stall_cycles_q <= '0;
            flush_events_q     <= '0;
        end else begin
            stall_cycles_q     <= stall_cycles_d;
            mdu_stall_cycles_q <= mdu_stall_cycles_d;
            flush_events_q     <= flush_events_d;
        end
    end

    assign StallCycles    = stall_cycles_q;
    assign MduStallCycles = mdu_stall_cycles_q;
    assign FlushEvents    = flush_events_q;
`endif

endmodule
